// File: rtl/reg_alu_pipe.sv
// reg_alu_pipe: register file plus ALU with a one-cycle result path and an
// optional iterative shift-add multiplier.
// Optional feature macro: REG_ALU_MUL_EN (enables opcode 01000 = MUL).
module reg_alu_pipe #(
  parameter int WIDTH  = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              write,
  input  logic              IMM_MUX,
  input  logic              mem_sel,
  input  logic [REG_AW-1:0] rSrc,
  input  logic [REG_AW-1:0] rDst,
  input  logic [4:0]        aluOp,
  input  logic [WIDTH-1:0]  imm,
  input  logic [WIDTH-1:0]  mem_data,
  output logic [WIDTH-1:0]  dSrc,
  output logic [WIDTH-1:0]  dDst,
  output logic [WIDTH-1:0]  result,
  output logic              out_valid,
  output logic [4:0]        psrOut
);

  localparam int NREG = 1 << REG_AW;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_CMP = 5'b00010;
  localparam logic [4:0] OP_AND = 5'b00011;
  localparam logic [4:0] OP_OR  = 5'b00100;
  localparam logic [4:0] OP_XOR = 5'b00101;
  localparam logic [4:0] OP_MOV = 5'b00110;
  localparam logic [4:0] OP_LSH = 5'b00111;
`ifdef REG_ALU_MUL_EN
  localparam logic [4:0] OP_MUL = 5'b01000;
  localparam int         CNT_W  = $clog2(WIDTH);
`endif

  // Flag bit positions inside the PSR
  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

  // Signed overflow of a+b: operands agree in sign, result does not
  function automatic logic add_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [WIDTH-1:0] r);
    return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  // Signed overflow of a-b: operands differ in sign, result sign flips from a
  function automatic logic sub_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [WIDTH-1:0] r);
    return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  logic [WIDTH-1:0] rf_q [NREG];
  logic [WIDTH-1:0] rf_d [NREG];
  logic [WIDTH-1:0] result_q, result_d;
  logic [4:0]       psr_q, psr_d;
  logic             out_valid_q, out_valid_d;

  logic             busy;
  logic             accept;
  logic [WIDTH-1:0] a_op, b_op;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] diff;
  logic [3:0]       shamt;
  logic [WIDTH-1:0] alu_res;
  logic [4:0]       alu_psr;
  logic             alu_wr;
  logic             upd_zn;
  logic             is_mul;

`ifdef REG_ALU_MUL_EN
  logic                 busy_q, busy_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [REG_AW-1:0]    mdst_q, mdst_d;
  logic                 mwr_q, mwr_d;
  logic [2*WIDTH-1:0]   acc_step;

  assign busy = busy_q;
`else
  assign busy = 1'b0;
`endif

  // Operand selection and handshake; register reads are purely combinational
  assign a_op      = rf_q[rDst];
  assign b_op      = IMM_MUX ? imm : rf_q[rSrc];
  assign in_ready  = !busy;
  assign accept    = in_valid && in_ready;
  assign dSrc      = rf_q[rSrc];
  assign dDst      = rf_q[rDst];
  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign psrOut    = psr_q;

  // Single-cycle ALU: result, flag image and writeback enable for this op
  always_comb begin
    sum_ext = {1'b0, a_op} + {1'b0, b_op};
    diff    = a_op - b_op;
    // Negative B shifts right by the magnitude of B
    shamt   = b_op[WIDTH-1] ? 4'(-b_op) : b_op[3:0];
    alu_res = a_op;
    alu_psr = psr_q;
    alu_wr  = write;
    upd_zn  = 1'b0;
    is_mul  = 1'b0;
    if (mem_sel) begin
      alu_res = mem_data;
    end else begin
      case (aluOp)
        OP_ADD: begin
          alu_res         = sum_ext[WIDTH-1:0];
          alu_psr[FLAG_C] = sum_ext[WIDTH];
          alu_psr[FLAG_F] = add_ovf(a_op, b_op, sum_ext[WIDTH-1:0]);
          upd_zn          = 1'b1;
        end
        OP_SUB: begin
          alu_res         = diff;
          alu_psr[FLAG_C] = a_op < b_op;
          alu_psr[FLAG_F] = sub_ovf(a_op, b_op, diff);
          upd_zn          = 1'b1;
        end
        OP_CMP: begin
          alu_res         = diff;
          alu_wr          = 1'b0;
          alu_psr[FLAG_Z] = a_op == b_op;
          alu_psr[FLAG_L] = a_op < b_op;
          alu_psr[FLAG_N] = $signed(a_op) < $signed(b_op);
        end
        OP_AND: begin alu_res = a_op & b_op; upd_zn = 1'b1; end
        OP_OR:  begin alu_res = a_op | b_op; upd_zn = 1'b1; end
        OP_XOR: begin alu_res = a_op ^ b_op; upd_zn = 1'b1; end
        OP_MOV: begin alu_res = b_op;        upd_zn = 1'b1; end
        OP_LSH: begin
          alu_res = b_op[WIDTH-1] ? (a_op >> shamt) : (a_op << shamt);
          upd_zn  = 1'b1;
        end
`ifdef REG_ALU_MUL_EN
        OP_MUL: begin
          is_mul = 1'b1;
          alu_wr = 1'b0;
        end
`endif
        default: ;
      endcase
      if (upd_zn) begin
        alu_psr[FLAG_Z] = alu_res == '0;
        alu_psr[FLAG_N] = alu_res[WIDTH-1];
      end
    end
  end

  // Next state: single-cycle commit, multiplier launch, iteration and completion
  always_comb begin
    rf_d        = rf_q;
    result_d    = result_q;
    psr_d       = psr_q;
    out_valid_d = 1'b0;
`ifdef REG_ALU_MUL_EN
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    mdst_d   = mdst_q;
    mwr_d    = mwr_q;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
    if (accept && !is_mul) begin
      result_d    = alu_res;
      psr_d       = alu_psr;
      out_valid_d = 1'b1;
      if (alu_wr) rf_d[rDst] = alu_res;
    end
`ifdef REG_ALU_MUL_EN
    if (accept && is_mul) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a_op};
      mplier_d = b_op;
      mdst_d   = rDst;
      mwr_d    = write;
    end
    // One multiplier bit per cycle; the last step commits directly
    if (busy_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        busy_d          = 1'b0;
        result_d        = acc_step[WIDTH-1:0];
        psr_d[FLAG_C]   = |acc_step[2*WIDTH-1:WIDTH];
        psr_d[FLAG_Z]   = acc_step[WIDTH-1:0] == '0;
        psr_d[FLAG_N]   = acc_step[WIDTH-1];
        out_valid_d     = 1'b1;
        if (mwr_q) rf_d[mdst_q] = acc_step[WIDTH-1:0];
      end
    end
`endif
  end

  // Architectural state with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      result_q    <= '0;
      psr_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef REG_ALU_MUL_EN
      busy_q      <= 1'b0;
      cnt_q       <= '0;
`endif
    end else begin
      rf_q        <= rf_d;
      result_q    <= result_d;
      psr_q       <= psr_d;
      out_valid_q <= out_valid_d;
`ifdef REG_ALU_MUL_EN
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

`ifdef REG_ALU_MUL_EN
  // Multiplier datapath registers; only meaningful while busy_q is set
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    mdst_q   <= mdst_d;
    mwr_q    <= mwr_d;
  end
`endif

endmodule

// File: tb/tb_reg_alu_pipe.sv
// Directed testbench for reg_alu_pipe (WIDTH=16, REG_AW=4).
// Multiplier scenarios are selected by REG_ALU_MUL_EN, matching the RTL build.
module tb_reg_alu_pipe;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_CMP = 5'b00010;
  localparam logic [4:0] OP_AND = 5'b00011;
  localparam logic [4:0] OP_OR  = 5'b00100;
  localparam logic [4:0] OP_XOR = 5'b00101;
  localparam logic [4:0] OP_MOV = 5'b00110;
  localparam logic [4:0] OP_LSH = 5'b00111;
  localparam logic [4:0] OP_MUL = 5'b01000;
  localparam logic [4:0] OP_BAD = 5'b11111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        write = 1'b0;
  logic        IMM_MUX = 1'b0;
  logic        mem_sel = 1'b0;
  logic [3:0]  rSrc = '0;
  logic [3:0]  rDst = '0;
  logic [4:0]  aluOp = '0;
  logic [15:0] imm = '0;
  logic [15:0] mem_data = '0;
  logic [15:0] dSrc, dDst, result;
  logic        out_valid;
  logic [4:0]  psrOut;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_alu_pipe #(.WIDTH(16), .REG_AW(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .write(write), .IMM_MUX(IMM_MUX), .mem_sel(mem_sel),
    .rSrc(rSrc), .rDst(rDst), .aluOp(aluOp), .imm(imm), .mem_data(mem_data),
    .dSrc(dSrc), .dDst(dDst), .result(result), .out_valid(out_valid), .psrOut(psrOut)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one operation for one accept edge, sample 1ns after it
  task automatic op(input logic wr, input logic im, input logic ms, input int src, input int dst,
                    input logic [4:0] opc, input logic [15:0] iv, input logic [15:0] md);
    write = wr; IMM_MUX = im; mem_sel = ms;
    rSrc = 4'(src); rDst = 4'(dst); aluOp = opc; imm = iv; mem_data = md;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic load(input int dst, input logic [15:0] v);
    op(1'b1, 1'b0, 1'b1, 0, dst, OP_ADD, 16'h0, v);
  endtask

  task automatic alui(input logic [4:0] opc, input int dst, input logic [15:0] iv, input logic wr);
    op(wr, 1'b1, 1'b0, 0, dst, opc, iv, 16'h0);
  endtask

  task automatic rd(input int r, output logic [15:0] v);
    rSrc = 4'(r); #1; v = dSrc;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    int k;
    int pulses;
    logic done;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_result", result, 16'h0);
    check("rst_psr", psrOut, 5'h00);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    rSrc = 4'd3; rDst = 4'd15; #1;
    check("rst_dsrc", dSrc, 16'h0);
    check("rst_ddst", dDst, 16'h0);

    // Load path and signed-overflow add
    load(1, 16'h7FFF);
    check("load_valid", out_valid, 1'b1);
    check("load_result", result, 16'h7FFF);
    check("load_psr_held", psrOut, 5'h00);
    load(2, 16'h0001);
    op(1'b1, 1'b0, 1'b0, 2, 1, OP_ADD, 16'h0, 16'h0);
    check("add_ovf_result", result, 16'h8000);
    check("add_ovf_valid", out_valid, 1'b1);
    check("add_ovf_psr", psrOut, 5'h14);
    idle();
    check("add_ovf_pulse", out_valid, 1'b0);
    check("add_ovf_r1", dDst, 16'h8000);

    // Carry out and zero
    load(1, 16'hFFFF);
    alui(OP_ADD, 1, 16'h0001, 1'b1);
    check("add_carry_result", result, 16'h0000);
    check("add_carry_psr", psrOut, 5'h09);
    rd(1, v); check("add_carry_r1", v, 16'h0000);

    // Compare: equal, unsigned/signed less-than, no writeback
    load(1, 16'h0005);
    alui(OP_CMP, 1, 16'h0005, 1'b1);
    check("cmp_eq_psr", psrOut, 5'h09);
    rd(1, v); check("cmp_no_wb", v, 16'h0005);
    alui(OP_CMP, 1, 16'h0006, 1'b1);
    check("cmp_lt_psr", psrOut, 5'h13);
    alui(OP_CMP, 1, 16'hFFFF, 1'b1);
    check("cmp_unsigned_lt_psr", psrOut, 5'h03);

    // Back-to-back write then read of the same register
    alui(OP_MOV, 3, 16'h1234, 1'b1);
    check("mov_result", result, 16'h1234);
    check("mov_psr", psrOut, 5'h03);
    op(1'b1, 1'b0, 1'b0, 3, 4, OP_ADD, 16'h0, 16'h0);
    check("b2b_result", result, 16'h1234);
    check("b2b_psr", psrOut, 5'h02);
    check("b2b_r4", dDst, 16'h1234);

    // Subtract: overflow and borrow
    load(5, 16'h8000);
    alui(OP_SUB, 5, 16'h0001, 1'b1);
    check("sub_ovf_result", result, 16'h7FFF);
    check("sub_ovf_psr", psrOut, 5'h06);
    alui(OP_SUB, 6, 16'h0001, 1'b1);
    check("sub_borrow_result", result, 16'hFFFF);
    check("sub_borrow_psr", psrOut, 5'h13);

    // Shifts: left, logical right by negative amount, max shift
    load(7, 16'h00F0);
    alui(OP_LSH, 7, 16'h0004, 1'b1);
    check("lsh_left", result, 16'h0F00);
    check("lsh_left_psr", psrOut, 5'h03);
    alui(OP_LSH, 7, 16'hFFFC, 1'b1);
    check("lsh_right", result, 16'h00F0);
    load(7, 16'h8001);
    alui(OP_LSH, 7, 16'hFFFF, 1'b1);
    check("lsh_right_logical", result, 16'h4000);
    alui(OP_LSH, 7, 16'h000F, 1'b1);
    check("lsh_15", result, 16'h0000);
    check("lsh_15_psr", psrOut, 5'h0B);

    // Logic ops
    load(8, 16'h0F0F);
    alui(OP_AND, 8, 16'h00FF, 1'b0);
    check("and_result", result, 16'h000F);
    check("and_psr", psrOut, 5'h03);
    check("and_no_write", dDst, 16'h0F0F);
    alui(OP_OR, 8, 16'hF000, 1'b1);
    check("or_result", result, 16'hFF0F);
    check("or_psr", psrOut, 5'h13);
    alui(OP_XOR, 8, 16'hFF0F, 1'b1);
    check("xor_result", result, 16'h0000);
    check("xor_psr", psrOut, 5'h0B);

    // Unrecognized opcode: result = A, flags held
    alui(OP_BAD, 1, 16'h0777, 1'b1);
    check("bad_op_result", result, 16'h0005);
    check("bad_op_psr", psrOut, 5'h0B);
    check("bad_op_valid", out_valid, 1'b1);

    // R0 is an ordinary register
    load(0, 16'hABCD);
    rd(0, v); check("r0_write", v, 16'hABCD);

    alui(OP_ADD, 9, 16'h0001, 1'b1);
    check("add_r9_psr", psrOut, 5'h02);
    load(1, 16'h0100);

`ifdef REG_ALU_MUL_EN
    alui(OP_MUL, 1, 16'h0100, 1'b1);
    check("mul_start_rdy", in_ready, 1'b0);
    check("mul_start_valid", out_valid, 1'b0);
    k = 0; done = 1'b0;
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (k == 2) begin
        write = 1'b1; IMM_MUX = 1'b1; mem_sel = 1'b0; rDst = 4'd10;
        aluOp = OP_MOV; imm = 16'h5555; in_valid = 1'b1;
      end
      if (k == 3) in_valid = 1'b0;
      if (k == 15) check("mul_busy_rdy", in_ready, 1'b0);
      if (out_valid) done = 1'b1;
    end
    check("mul_latency", k, 16);
    check("mul_done_rdy", in_ready, 1'b1);
    check("mul_result", result, 16'h0000);
    check("mul_psr", psrOut, 5'h0B);
    rd(1, v); check("mul_r1", v, 16'h0000);
    rd(10, v); check("mul_ignored_op", v, 16'h0000);
    idle();
    check("mul_pulse", out_valid, 1'b0);

    load(2, 16'h0003);
    alui(OP_MUL, 2, 16'h0005, 1'b1);
    k = 0; done = 1'b0;
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (out_valid) done = 1'b1;
    end
    check("mul2_latency", k, 16);
    check("mul2_result", result, 16'h000F);
    check("mul2_psr", psrOut, 5'h02);

    // Reset five cycles into a multiply aborts it
    load(1, 16'h0003);
    alui(OP_MUL, 1, 16'h0002, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
`else
    alui(OP_MUL, 1, 16'h0100, 1'b1);
    check("nomul_valid", out_valid, 1'b1);
    check("nomul_rdy", in_ready, 1'b1);
    check("nomul_result", result, 16'h0100);
    check("nomul_psr", psrOut, 5'h02);
    rd(1, v); check("nomul_r1", v, 16'h0100);

    load(1, 16'h0003);
    idle();
    reset = 1'b1;
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_rdy", in_ready, 1'b1);
    check("abort_valid", out_valid, 1'b0);
    check("abort_result", result, 16'h0000);
    check("abort_psr", psrOut, 5'h00);
    rd(1, v); check("abort_r1", v, 16'h0000);
    rd(0, v); check("abort_r0", v, 16'h0000);
    pulses = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    rd(1, v); check("abort_r1_late", v, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_alu_pipe.md
REG_ALU_PIPE -- requirements
Module: reg_alu_pipe

Interface
REQ-001 Parameter WIDTH, default 16, datapath and register width (>=8).
REQ-002 Parameter REG_AW, default 4, register address width; register count 2**REG_AW.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  operation presented this cycle.
REQ-006 in_ready  out  1  block accepts an operation; transfer = in_valid && in_ready at a rising edge.
REQ-007 write  in  1  write the result to R[rDst].
REQ-008 IMM_MUX  in  1  operand B = imm instead of R[rSrc].
REQ-009 mem_sel  in  1  result = mem_data (load path); the ALU is bypassed.
REQ-010 rSrc, rDst  in  REG_AW each  source and destination register addresses.
REQ-011 aluOp  in  5  operation code.
REQ-012 imm, mem_data  in  WIDTH each  immediate and memory load data.
REQ-013 dSrc, dDst  out  WIDTH each  combinational reads of R[rSrc] and R[rDst].
REQ-014 result  out  WIDTH  registered result of the last completed operation.
REQ-015 out_valid  out  1  one-cycle pulse marking a completed operation.
REQ-016 psrOut  out  5  flags; bit 0 C, bit 1 L, bit 2 F, bit 3 Z, bit 4 N.

Function
REQ-017 Operands: A = R[rDst]; B = IMM_MUX ? imm : R[rSrc]; all arithmetic is modulo 2**WIDTH.
REQ-018 Opcodes and results:
- 00000 ADD: A+B.
- 00001 SUB: A-B.
- 00010 CMP: flags only; no writeback even when write=1.
- 00011 AND, 00100 OR, 00101 XOR.
- 00110 MOV: B.
- 00111 LSH: B[WIDTH-1]=0 -> A<<B[3:0]; B[WIDTH-1]=1 -> A>>(-B)[3:0], logical.
- 01000 MUL: iterative multiply (REQ-025).
- Any other code: result = A; flags unchanged.
REQ-019 Flag updates by operation:
- ADD: C = unsigned carry-out; F = signed overflow.
- SUB: C = borrow (A<B unsigned); F = signed overflow.
- ADD, SUB, logic ops, MOV, LSH: Z = result==0; N = result MSB.
- CMP: Z = A==B; L = A<B unsigned; N = A<B signed.
- Flags not listed for an operation hold their value.
REQ-020 mem_sel=1: result = mem_data; the PSR is not modified; aluOp is ignored.
REQ-021 Single-cycle ops: on the accept edge, the register write, PSR update and result all take effect; out_valid is high for the following cycle only (latency 1).
REQ-022 A write at edge N is visible on dSrc/dDst and to an operation accepted at edge N+1; no forwarding is needed.
REQ-023 in_ready = !busy; in_valid while busy is ignored and not queued.
REQ-024 All registers are writable, including R0.
REQ-025 MUL uses a shift-add unit, one multiplier bit per cycle.
- Accept at edge N sets busy; completion at edge N+WIDTH.
- On completion, the low WIDTH bits are written (if write=1) and drive result; out_valid pulses; busy clears.
- in_ready returns high in the cycle after completion.
- Flags: Z and N from the low half; C = (high half != 0); F and L held.

Reset
REQ-026 While reset=1 at a rising edge, the block returns to its reset state:
- All registers, result and psrOut clear to 0.
- out_valid=0, busy=0, in_ready=1.
REQ-027 Reset has priority over any accept or completion in the same cycle; a multiply in progress is aborted with no write and no out_valid.

Configuration
REQ-028 Macro REG_ALU_MUL_EN: when defined, opcode 01000 is MUL per REQ-025; when undefined, no multiplier logic exists, busy is constantly 0, and 01000 behaves as an unrecognized opcode.

Verification
REQ-029 The bench shall cover the following scenarios (WIDTH=16):
- Load R1=0x7FFF and R2=0x0001 via mem_sel; ADD rDst=1, rSrc=2 -> R1=0x8000, result=0x8000, out_valid one cycle, N=1, F=1, C=0, Z=0.
- R1=0xFFFF; ADD IMM_MUX imm=0x0001 -> R1=0x0000, C=1, Z=1, N=0.
- R1=0x0005; CMP IMM_MUX imm=0x0005, write=1 -> Z=1, L=0, N=0; R1 remains 0x0005.
- Back-to-back: MOV imm 0x1234 into R3, then next cycle ADD rDst=4, rSrc=3 with R4=0 -> R4=0x1234.
- MUL_EN: R1=0x0100 MUL imm 0x0100 -> in_ready low 16 cycles, result=0x0000, Z=1, C=1; without the macro -> result=0x0100, latency 1, flags unchanged.
- MUL_EN: assert reset 5 cycles into a MUL -> no out_valid, all registers 0, in_ready=1 in the cycle after reset is released.
